// File: rtl/mod_arith_pkg.sv
// Shared definitions for the modular arithmetic datapath: op encoding and
// the modulus correction applied to a raw add/sub result.
package mod_arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest raw value the correction helper handles (operands up to 32 bits).
  localparam int unsigned CORR_W = 33;

  // Corrected value: add results are pulled down by m, sub results pushed up by m.
  function automatic logic [CORR_W-1:0] mod_corr(input logic [CORR_W-1:0] r,
                                                 input logic              op,
                                                 input logic [CORR_W-1:0] m);
    mod_corr = (op == OP_SUB) ? r + m : r - m;
  endfunction

endpackage

// File: rtl/mod_addsub_core.sv
// Combinational first-stage datapath: raw a +/- b, its modulus-corrected
// counterpart and the operand range error.
module mod_addsub_core
  import mod_arith_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned M = 13
) (
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N:0]   r,
  output logic [N:0]   c,
  output logic         err1
);

  localparam int unsigned W = N + 1;
  localparam logic [W-1:0] M_W = W'(M);

  logic [W-1:0] w_b_addend;
  logic [W-1:0] w_corr_k;

  // Kogge-Stone prefix adder with carry-in.
  function automatic logic [W-1:0] ks_add(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic         cin);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] h;
    logic [W-1:0] gn;
    logic [W-1:0] pn;
    h    = x ^ y;
    p    = h;
    g    = x & y;
    g[0] = g[0] | (p[0] & cin);
    for (int unsigned d = 1; d < W; d = d * 2) begin
      gn = g;
      pn = p;
      for (int unsigned i = d; i < W; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    return h ^ {g[W-2:0], cin};
  endfunction

  assign w_b_addend = (op == OP_SUB) ? ~{1'b0, b} : {1'b0, b};
  // Correcting the value zero yields the signed constant +M or -M.
  assign w_corr_k   = W'(mod_corr('0, op, CORR_W'(M)));

  assign r    = ks_add({1'b0, a}, w_b_addend, op);
  assign c    = ks_add(r, w_corr_k, 1'b0);
  assign err1 = ({1'b0, a} >= M_W) || ({1'b0, b} >= M_W);

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined (a +/- b) mod M with valid/ready on both sides,
// operand range checking and a wrapping output-handshake counter.
module mod_addsub_pipe
  import mod_arith_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned M  = 13,
  parameter int unsigned TW = 4,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          op,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  result,
  output logic          err,
  output logic [TW-1:0] out_tag,
  output logic [CW-1:0] count
);

  localparam int unsigned W = N + 1;
  localparam logic [W-1:0] M_W = W'(M);

  if (N < 2 || N > 32 || M < 2 || 64'(M) > (64'd1 << N)) begin : g_param_check
    $error("mod_addsub_pipe: need 2 <= N <= 32 and 2 <= M <= 2**N");
  end

  logic          r_s1_valid;
  logic          r_s1_op;
  logic [W-1:0]  r_s1_r;
  logic [W-1:0]  r_s1_c;
  logic          r_s1_err;
  logic [TW-1:0] r_s1_tag;

  logic          r_s2_valid;
  logic [N-1:0]  r_result;
  logic          r_err;
  logic [TW-1:0] r_tag;
  logic [CW-1:0] r_count;

  logic [W-1:0]  w_r;
  logic [W-1:0]  w_c;
  logic          w_err1;
  logic [N-1:0]  w_sel;
  logic          w_s2_free;
  logic          w_s1_move;
  logic          w_in_xfer;
  logic          w_out_xfer;

  mod_addsub_core #(.N(N), .M(M)) u_core (
    .op   (op),
    .a    (a),
    .b    (b),
    .r    (w_r),
    .c    (w_c),
    .err1 (w_err1)
  );

  assign w_s2_free  = !r_s2_valid || out_ready;
  assign w_s1_move  = r_s1_valid && w_s2_free;
  // rst term keeps in_ready high while stale valid bits are being cleared.
  assign in_ready   = rst || !r_s1_valid || w_s2_free;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_s2_valid && out_ready;

  // Second-stage result selection.
  always_comb begin
    w_sel = N'(r_s1_r);
    if (r_s1_err) begin
      w_sel = '0;
    end else if (r_s1_op == OP_SUB) begin
      if (r_s1_r[N]) w_sel = N'(r_s1_c);
    end else if (r_s1_r >= M_W) begin
      w_sel = N'(r_s1_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_ADD;
      r_s1_r     <= '0;
      r_s1_c     <= '0;
      r_s1_err   <= 1'b0;
      r_s1_tag   <= '0;
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_err      <= 1'b0;
      r_tag      <= '0;
      r_count    <= '0;
    end else begin
      if (w_in_xfer) begin
        r_s1_valid <= 1'b1;
        r_s1_op    <= op;
        r_s1_r     <= w_r;
        r_s1_c     <= w_c;
        r_s1_err   <= w_err1;
        r_s1_tag   <= in_tag;
      end else if (w_s1_move) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s1_move) begin
        r_s2_valid <= 1'b1;
        r_result   <= w_sel;
        r_err      <= r_s1_err;
        r_tag      <= r_s1_tag;
      end else if (w_out_xfer) begin
        r_s2_valid <= 1'b0;
      end

      if (w_out_xfer) r_count <= r_count + CW'(1);
    end
  end

  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign err       = r_err;
  assign out_tag   = r_tag;
  assign count     = r_count;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Directed bench for mod_addsub_pipe (N=4, M=13): vector table plus
// back-pressure, error streaming, mid-flight reset and counter wrap sequences.
module tb_mod_addsub_pipe;

  typedef struct {
    logic       op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] tag;
    logic [3:0] exp_res;
    logic       exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       op;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] in_tag;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic       err;
  logic [3:0] out_tag;
  logic [7:0] count;

  int n_pass  = 0;
  int n_total = 0;

  vec_t vecs[13];
  vec_t bp[4];

  always #5 clk = ~clk;

  mod_addsub_pipe #(.N(4), .M(13), .TW(4), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .out_tag   (out_tag),
    .count     (count)
  );

  function automatic vec_t mk(input logic o, input int va, input int vb,
                              input int t, input int res, input logic e);
    vec_t v;
    v.op      = o;
    v.a       = 4'(va);
    v.b       = 4'(vb);
    v.tag     = 4'(t);
    v.exp_res = 4'(res);
    v.exp_err = e;
    return v;
  endfunction

  // Streaming operands for the wrap test, with a hand-written mod-13 model.
  function automatic vec_t stream_vec(input int i);
    int va;
    int vb;
    int res;
    va  = i % 13;
    vb  = (i * 7) % 13;
    res = (i % 2 == 1) ? (va - vb + 13) % 13 : (va + vb) % 13;
    return mk(1'((i % 2)), va, vb, i % 16, res, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act !== expv) $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    op     = v.op;
    a      = v.a;
    b      = v.b;
    in_tag = v.tag;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int   exp_cnt;
    int   lat;
    int   ii;
    int   oo;
    int   gaps;
    int   seen;
    int   acc_n;
    int   out_n;
    int   bad;
    logic acc;
    vec_t sv;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = 1'b0; a = '0; b = '0; in_tag = '0;

    vecs[0]  = mk(1'b0,  7,  9,  0,  3, 1'b0);
    vecs[1]  = mk(1'b1,  2,  5,  1, 10, 1'b0);
    vecs[2]  = mk(1'b1,  5,  5,  2,  0, 1'b0);
    vecs[3]  = mk(1'b0, 12,  0,  3, 12, 1'b0);
    vecs[4]  = mk(1'b0, 12,  1,  4,  0, 1'b0);
    vecs[5]  = mk(1'b1,  0, 12,  5,  1, 1'b0);
    vecs[6]  = mk(1'b0,  0,  0,  6,  0, 1'b0);
    vecs[7]  = mk(1'b1, 12,  0,  7, 12, 1'b0);
    vecs[8]  = mk(1'b0,  6,  6,  8, 12, 1'b0);
    vecs[9]  = mk(1'b0, 14,  3,  5,  0, 1'b1);
    vecs[10] = mk(1'b1,  3, 13, 10,  0, 1'b1);
    vecs[11] = mk(1'b0, 15, 15, 11,  0, 1'b1);
    vecs[12] = mk(1'b1,  1, 12, 12,  2, 1'b0);

    bp[0] = mk(1'b0,  3,  4, 1,  7, 1'b0);
    bp[1] = mk(1'b1,  1,  2, 2, 12, 1'b0);
    bp[2] = mk(1'b0, 10, 10, 3,  7, 1'b0);
    bp[3] = mk(1'b0, 11,  5, 4,  3, 1'b0);

    // Reset state
    #1;
    chk("ready_during_reset", 32'(in_ready), 1);
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    step();

    // Single operations from the vector table
    exp_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 1);
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 8) begin
        step();
        lat++;
      end
      chk($sformatf("vec%0d_latency", i), 32'(lat), 1);
      chk($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].exp_res));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_tag", i), 32'(out_tag), 32'(vecs[i].tag));
      step();
      exp_cnt++;
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(exp_cnt));
    end

    // Back-pressure: two accepts fill the pipe, then outputs hold
    out_ready = 1'b0;
    drive(bp[0]); in_valid = 1'b1; #1;
    chk("bp_ready0", 32'(in_ready), 1);
    step();
    drive(bp[1]); #1;
    chk("bp_ready1", 32'(in_ready), 1);
    step();
    drive(bp[2]); #1;
    chk("bp_ready_full", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    chk("bp_first_result", 32'(result), 32'(bp[0].exp_res));
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      chk($sformatf("bp_hold%0d_result", k), 32'(result), 32'(bp[0].exp_res));
      chk($sformatf("bp_hold%0d_tag", k), 32'(out_tag), 32'(bp[0].tag));
      chk($sformatf("bp_hold%0d_ready", k), 32'(in_ready), 0);
    end
    out_ready = 1'b1; #1;
    chk("bp_ready_release", 32'(in_ready), 1);
    ii = 2; oo = 0; gaps = 0;
    for (int cyc = 0; cyc < 12 && oo < 4; cyc++) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        chk($sformatf("bp_drain%0d_result", oo), 32'(result), 32'(bp[oo].exp_res));
        chk($sformatf("bp_drain%0d_tag", oo), 32'(out_tag), 32'(bp[oo].tag));
        oo++;
      end else begin
        gaps++;
      end
      step();
      if (acc) ii++;
      if (ii < 4) drive(bp[ii]);
      else in_valid = 1'b0;
      #1;
    end
    chk("bp_drain_count", 32'(oo), 4);
    chk("bp_drain_gaps", 32'(gaps), 0);
    exp_cnt += 4;
    chk("bp_count", 32'(count), 32'(exp_cnt));

    // Error operation followed back-to-back by a valid one
    in_valid = 1'b0;
    step();
    drive(mk(1'b0, 14, 3, 5, 0, 1'b1)); in_valid = 1'b1;
    step();
    drive(mk(1'b0, 1, 2, 6, 3, 1'b0));
    step();
    in_valid = 1'b0; #1;
    chk("errs_valid0", 32'(out_valid), 1);
    chk("errs_err0", 32'(err), 1);
    chk("errs_result0", 32'(result), 0);
    chk("errs_tag0", 32'(out_tag), 5);
    step(); #1;
    chk("errs_valid1", 32'(out_valid), 1);
    chk("errs_err1", 32'(err), 0);
    chk("errs_result1", 32'(result), 3);
    chk("errs_tag1", 32'(out_tag), 6);
    step();
    exp_cnt += 2;
    chk("errs_count", 32'(count), 32'(exp_cnt));

    // Reset with two operations in flight
    out_ready = 1'b0;
    drive(mk(1'b0, 1, 1, 9, 2, 1'b0)); in_valid = 1'b1;
    step();
    drive(mk(1'b0, 2, 2, 10, 4, 1'b0));
    step();
    in_valid = 1'b0; #1;
    chk("mid_pre_valid", 32'(out_valid), 1);
    rst = 1'b1; #1;
    chk("mid_ready_in_reset", 32'(in_ready), 1);
    step();
    chk("mid_out_valid", 32'(out_valid), 0);
    chk("mid_count", 32'(count), 0);
    chk("mid_in_ready", 32'(in_ready), 1);
    rst = 1'b0; out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (out_valid) seen++;
    end
    chk("mid_no_ghosts", 32'(seen), 0);

    // 256 streamed transfers wrap the 8-bit counter
    acc_n = 0; out_n = 0; bad = 0;
    for (int cyc = 0; cyc < 400 && out_n < 256; cyc++) begin
      if (acc_n < 256) begin
        drive(stream_vec(acc_n));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        sv = stream_vec(out_n);
        if (result !== sv.exp_res || err !== 1'b0 || out_tag !== sv.tag) bad++;
        out_n++;
      end
      step();
      if (acc) acc_n++;
      if (out_valid && out_n == 255) chk("wrap_count_255", 32'(count), 255);
    end
    in_valid = 1'b0;
    chk("wrap_transfers", 32'(out_n), 256);
    chk("wrap_stream_errors", 32'(bad), 0);
    chk("wrap_count_zero", 32'(count), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
